// File: rtl/fpu_cmd_issuer.sv
// fpu_cmd_issuer: initiator side of the FPU start/ready/done handshake.
// Buffers FP32 requests in a small FIFO, issues them one at a time to the FPU,
// and returns one tagged response (result, flags, status) per request, in order.
// Optional macro FPU_ISSUE_TIMEOUT_EN adds a WAIT-state timeout (status 10).
module fpu_cmd_issuer #(
  parameter int DEPTH       = 4,
  parameter int TAG_W       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [1:0]       cmd_mode,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             fpu_start,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_mode,
  input  logic             fpu_ready,
  input  logic             fpu_done,
  input  logic [31:0]      fpu_s,
  input  logic             fpu_zero,
  input  logic             fpu_nan,
  input  logic             fpu_inf,
  input  logic             fpu_error,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [1:0]       rsp_status,
  output logic [TAG_W-1:0] rsp_tag
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = 32 + 32 + 2 + TAG_W;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_RESP} state_t;

  state_t state_q, state_d;

  logic [ENT_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             fifo_full, fifo_empty, push, pop;
  logic [ENT_W-1:0] head;

  logic [TAG_W-1:0] op_tag_q;
  logic             busy_seen_q;
  logic             wait_done, wait_abort, wait_tmo;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push       = cmd_valid & cmd_ready;
  assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  // Done wins over abort when the FPU shows ready and done together.
  assign wait_done  = (state_q == S_WAIT) & fpu_done;
  assign wait_abort = (state_q == S_WAIT) & ~fpu_done & fpu_ready & busy_seen_q;

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt_q;

  // Count WAIT cycles since the operation was issued
  always_ff @(posedge clk_i) begin
    if (rst_i)                   tmo_cnt_q <= '0;
    else if (state_q == S_ISSUE) tmo_cnt_q <= '0;
    else if (state_q == S_WAIT)  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
  end

  assign wait_tmo = (state_q == S_WAIT) & ~fpu_done & ~wait_abort &
                    (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign wait_tmo = 1'b0;
`endif

  // Command FIFO storage; pop frees a slot only from the next cycle on
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {cmd_a, cmd_b, cmd_mode, cmd_tag};
  end

  // FIFO pointers with an extra wrap bit for full/empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pop) state_d = S_ISSUE;
      S_ISSUE: if (fpu_start) state_d = S_WAIT;
      S_WAIT: begin
        if (wait_done)                  state_d = S_CAPT;
        else if (wait_abort || wait_tmo) state_d = S_RESP;
      end
      S_CAPT:  state_d = S_RESP;
      S_RESP:  if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; start is held back while the FPU is not idle
  always_comb begin
    rsp_valid = (state_q == S_RESP);
    cmd_ready = ~fifo_full;
    pop       = (state_q == S_IDLE) & ~fifo_empty & fpu_ready & ~rsp_valid;
    fpu_start = (state_q == S_ISSUE) & fpu_ready & ~rsp_valid;
  end

  // Operand hold registers and response capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpu_a       <= '0;
      fpu_b       <= '0;
      fpu_mode    <= '0;
      op_tag_q    <= '0;
      busy_seen_q <= 1'b0;
      rsp_result  <= '0;
      rsp_flags   <= '0;
      rsp_status  <= '0;
      rsp_tag     <= '0;
    end else begin
      if (pop) {fpu_a, fpu_b, fpu_mode, op_tag_q} <= head;

      if (state_q == S_ISSUE)                   busy_seen_q <= 1'b0;
      else if (state_q == S_WAIT && !fpu_ready) busy_seen_q <= 1'b1;

      if (wait_done) rsp_flags <= {fpu_error, fpu_nan, fpu_inf, fpu_zero};

      if (wait_abort) begin
        rsp_flags  <= {fpu_error, fpu_nan, fpu_inf, fpu_zero};
        rsp_result <= '0;
        rsp_status <= ST_ABORT;
        rsp_tag    <= op_tag_q;
      end

      if (wait_tmo) begin
        rsp_flags  <= '0;
        rsp_result <= '0;
        rsp_status <= ST_TIMEOUT;
        rsp_tag    <= op_tag_q;
      end

      // fpu_s is written at the end of the FPU WRITE state, so it is valid only here
      if (state_q == S_CAPT) begin
        rsp_result <= fpu_s;
        rsp_status <= ST_OK;
        rsp_tag    <= op_tag_q;
      end
    end
  end

endmodule
